// File: rtl/led_blink_pkg.sv
// Shared definitions for the multi-channel LED blink controller: mode codes,
// the per-channel configuration record and a width helper.
package led_blink_pkg;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_ON      = 2'b01;
  localparam logic [1:0] MODE_BLINK   = 2'b10;
  localparam logic [1:0] MODE_PATTERN = 2'b11;

  // Record fields are sized for the widest supported build; channels use the low bits.
  localparam int unsigned DIV_W_MAX = 32;
  localparam int unsigned PAT_W_MAX = 16;

  typedef struct packed {
    logic [DIV_W_MAX-1:0] div;
    logic [1:0]           mode;
    logic [PAT_W_MAX-1:0] pat;
    logic                 inv;
  } cfg_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_blink_chan.sv
// One LED channel: configuration registers, period divider, blink/pattern
// state and the registered LED/TICK outputs.
module led_blink_chan
  import led_blink_pkg::*;
#(
  parameter int unsigned DIV_W       = 25,
  parameter int unsigned DIV_DEFAULT = 25000000,
  parameter int unsigned PAT_W       = 8
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic ce,
  input  logic we,
  input  cfg_t wr_cfg,
  output logic led,
  output logic tick
);

  localparam int unsigned PTR_W     = clog2_min1(PAT_W);
  localparam int unsigned PAT_IDX_W = clog2_min1(PAT_W_MAX);
  localparam cfg_t CFG_RESET = '{
    div:  DIV_W_MAX'(DIV_DEFAULT),
    mode: MODE_BLINK,
    pat:  '0,
    inv:  1'b0
  };

  cfg_t             cfg_q, cfg_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
  logic             tgl_q, tgl_d;
  logic             led_q, led_d;
  logic             tick_q, tick_d;
  logic             hit;

  assign hit     = (DIV_W_MAX'(cnt_q) == cfg_q.div);
  assign ptr_inc = (ptr_q == PTR_W'(PAT_W - 1)) ? '0 : ptr_q + PTR_W'(1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cfg_q  <= CFG_RESET;
      cnt_q  <= '0;
      ptr_q  <= '0;
      tgl_q  <= 1'b0;
      led_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      cnt_q  <= cnt_d;
      ptr_q  <= ptr_d;
      tgl_q  <= tgl_d;
      led_q  <= led_d;
      tick_q <= tick_d;
    end
  end

  // A write takes priority over a coincident tick and restarts the period.
  always_comb begin
    cfg_d  = cfg_q;
    cnt_d  = cnt_q;
    ptr_d  = ptr_q;
    tgl_d  = tgl_q;
    led_d  = led_q;
    tick_d = 1'b0;
    if (we) begin
      cfg_d = wr_cfg;
      cnt_d = '0;
      ptr_d = '0;
      tgl_d = 1'b0;
      unique case (wr_cfg.mode)
        MODE_OFF:     led_d = wr_cfg.inv;
        MODE_ON:      led_d = ~wr_cfg.inv;
        MODE_BLINK:   led_d = wr_cfg.inv;
        MODE_PATTERN: led_d = wr_cfg.pat[0] ^ wr_cfg.inv;
      endcase
    end else if (ce) begin
      if (hit) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        unique case (cfg_q.mode)
          MODE_OFF:   led_d = cfg_q.inv;
          MODE_ON:    led_d = ~cfg_q.inv;
          MODE_BLINK: begin
            tgl_d = ~tgl_q;
            led_d = ~tgl_q ^ cfg_q.inv;
          end
          MODE_PATTERN: begin
            ptr_d = ptr_inc;
            led_d = cfg_q.pat[PAT_IDX_W'(ptr_inc)] ^ cfg_q.inv;
          end
        endcase
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  assign led  = led_q;
  assign tick = tick_q;

endmodule

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED driver: decodes the config write port into per-channel
// write enables, instantiates the channels and acknowledges accepted writes.
module led_blink_ctrl
  import led_blink_pkg::*;
#(
  parameter int unsigned CH          = 3,
  parameter int unsigned DIV_W       = 25,
  parameter int unsigned DIV_DEFAULT = 25000000,
  parameter int unsigned PAT_W       = 8
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       CE,
  input  logic                       CFG_WE,
  input  logic [clog2_min1(CH)-1:0]  CFG_CH,
  input  logic [1:0]                 CFG_MODE,
  input  logic [DIV_W-1:0]           CFG_DIV,
  input  logic [PAT_W-1:0]           CFG_PAT,
  input  logic                       CFG_INV,
  output logic                       CFG_ACK,
  output logic [CH-1:0]              LED,
  output logic [CH-1:0]              TICK
);

  localparam int unsigned CW = clog2_min1(CH);

  cfg_t          wr_cfg;
  logic [CH-1:0] ch_we;
  logic          ack_q;

  always_comb begin
    wr_cfg = '{
      div:  DIV_W_MAX'(CFG_DIV),
      mode: CFG_MODE,
      pat:  PAT_W_MAX'(CFG_PAT),
      inv:  CFG_INV
    };
  end

  // Out-of-range channel numbers match no enable, so they are dropped unacknowledged.
  for (genvar i = 0; i < CH; i++) begin : g_chan
    assign ch_we[i] = CFG_WE && (CFG_CH == CW'(i));

    led_blink_chan #(
      .DIV_W       (DIV_W),
      .DIV_DEFAULT (DIV_DEFAULT),
      .PAT_W       (PAT_W)
    ) u_chan (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .ce     (CE),
      .we     (ch_we[i]),
      .wr_cfg (wr_cfg),
      .led    (LED[i]),
      .tick   (TICK[i])
    );
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= |ch_we;
    end
  end

  assign CFG_ACK = ack_q;

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Scoreboard bench for led_blink_ctrl: stimulus queues per-edge expectations,
// a negedge monitor compares them against LED/TICK/CFG_ACK.
module tb_led_blink_ctrl;
  import led_blink_pkg::*;

  localparam int K_LED = 0;
  localparam int K_TICK = 1;
  localparam int K_ACK = 2;

  logic        CLK, RST_N, CE, CFG_WE, CFG_INV, CFG_ACK;
  logic [1:0]  CFG_CH, CFG_MODE;
  logic [24:0] CFG_DIV;
  logic [7:0]  CFG_PAT;
  logic [2:0]  LED, TICK;

  led_blink_ctrl #(
    .CH          (3),
    .DIV_W       (25),
    .DIV_DEFAULT (4),
    .PAT_W       (8)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .CE       (CE),
    .CFG_WE   (CFG_WE),
    .CFG_CH   (CFG_CH),
    .CFG_MODE (CFG_MODE),
    .CFG_DIV  (CFG_DIV),
    .CFG_PAT  (CFG_PAT),
    .CFG_INV  (CFG_INV),
    .CFG_ACK  (CFG_ACK),
    .LED      (LED),
    .TICK     (TICK)
  );

  typedef struct {
    int    at;
    int    kind;
    int    ch;
    logic  val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   edges = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    edges++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, actual still running, required finished");
    $fatal(1, "watchdog");
  end

  // Monitor: every negedge, compare all expectations due at the current edge count.
  initial forever begin
    int   k;
    logic act;
    @(negedge CLK);
    k = 0;
    while (k < sb.size()) begin
      if (sb[k].at <= edges) begin
        n_checks++;
        case (sb[k].kind)
          K_LED:   act = LED[sb[k].ch];
          K_TICK:  act = TICK[sb[k].ch];
          default: act = CFG_ACK;
        endcase
        if (sb[k].at < edges) begin
          n_fail++;
          $display("FAIL %s missed at edge %0d (due %0d)", sb[k].name, edges, sb[k].at);
        end else if (act !== sb[k].val) begin
          n_fail++;
          $display("FAIL %s edge %0d kind %0d ch %0d: actual %b required %b",
                   sb[k].name, edges, sb[k].kind, sb[k].ch, act, sb[k].val);
        end
        sb.delete(k);
      end else begin
        k++;
      end
    end
  end

  task automatic push(input int at, input int kind, input int ch, input logic val,
                      input string name);
    exp_t e;
    e.at = at; e.kind = kind; e.ch = ch; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_write(input int ch, input logic [1:0] mode, input int div,
                          input logic [7:0] pat, input logic inv);
    CFG_WE = 1'b1; CFG_CH = 2'(ch); CFG_MODE = mode;
    CFG_DIV = 25'(div); CFG_PAT = pat; CFG_INV = inv;
    wait_edges(1);
    CFG_WE = 1'b0;
  endtask

  // Default blink (div 4) on channel c, i edges after the first enabled edge.
  task automatic push_default(input int at, input int i, input int c, input string name);
    push(at, K_LED, c, ((i + 1) / 5) % 2 == 1, name);
    push(at, K_TICK, c, (i % 5) == 4, name);
  endtask

  initial begin
    int e0, w, w3, w4, wi, t, wb, n, e0b;
    logic [7:0] pat_a3;
    pat_a3 = 8'hA3;
    RST_N = 1'b0; CE = 1'b0; CFG_WE = 1'b0; CFG_CH = '0; CFG_MODE = '0;
    CFG_DIV = '0; CFG_PAT = '0; CFG_INV = 1'b0;

    // Reset state
    for (int a = 1; a <= 2; a++) begin
      for (int c = 0; c < 3; c++) begin
        push(a, K_LED, c, 1'b0, "reset_led");
        push(a, K_TICK, c, 1'b0, "reset_tick");
      end
      push(a, K_ACK, 0, 1'b0, "reset_ack");
    end
    wait_edges(2);
    RST_N = 1'b1; CE = 1'b1;

    // 1: default blink on all channels
    e0 = edges + 1;
    for (int i = 0; i < 20; i++) begin
      for (int c = 0; c < 3; c++) push_default(e0 + i, i, c, "t1_blink");
      push(e0 + i, K_ACK, 0, 1'b0, "t1_ack");
    end
    wait_edges(20);

    // 2: ch1 pattern A3, div 1
    w = edges + 1;
    push(w, K_ACK, 0, 1'b1, "t2_ack");
    push(w + 1, K_ACK, 0, 1'b0, "t2_ack_end");
    for (int j = 0; j < 20; j++) begin
      push(w + j, K_LED, 1, pat_a3[(j / 2) % 8], "t2_pat_led");
      push(w + j, K_TICK, 1, (j > 0) && (j % 2 == 0), "t2_pat_tick");
      push_default(w + j, w + j - e0, 0, "t2_ch0_blink");
    end
    do_write(1, MODE_PATTERN, 1, 8'hA3, 1'b0);
    wait_edges(19);

    // 3: ch0 blink div 9, CE low for 7 edges at cnt 3
    w3 = edges + 1;
    push(w3, K_ACK, 0, 1'b1, "t3_ack");
    push(w3 + 1, K_ACK, 0, 1'b0, "t3_ack_end");
    for (int j = 0; j < 19; j++) begin
      push(w3 + j, K_LED, 0, j >= 17, "t3_freeze_led");
      push(w3 + j, K_TICK, 0, j == 17, "t3_freeze_tick");
    end
    do_write(0, MODE_BLINK, 9, 8'h00, 1'b0);
    wait_edges(3);
    CE = 1'b0;
    wait_edges(7);
    CE = 1'b1;
    wait_edges(8);

    // 4: ch2 blink div 0, inverted
    w4 = edges + 1;
    push(w4, K_ACK, 0, 1'b1, "t4_ack");
    for (int j = 0; j < 15; j++) begin
      push(w4 + j, K_LED, 2, (j % 2) == 0, "t4_fast_led");
      push(w4 + j, K_TICK, 2, j > 0, "t4_fast_tick");
    end
    do_write(2, MODE_BLINK, 0, 8'h00, 1'b1);
    wait_edges(2);

    // 5a: out-of-range channel is ignored
    wi = edges + 1;
    push(wi, K_ACK, 0, 1'b0, "t5_bad_ack");
    push(wi + 1, K_ACK, 0, 1'b0, "t5_bad_ack2");
    for (int e = wi; e < wi + 4; e++) begin
      push(e, K_TICK, 0, ((e - (w3 + 17)) % 10) == 0, "t5_ch0_kept");
    end
    do_write(3, MODE_ON, 5, 8'hFF, 1'b1);
    wait_edges(3);

    // 5b: write ch0 on its terminal-count edge
    t = w3 + 17;
    while (t < edges + 1) t += 10;
    wait_edges(t - 1 - edges);
    push(t, K_ACK, 0, 1'b1, "t5_tc_ack");
    push(t + 1, K_ACK, 0, 1'b0, "t5_tc_ack_end");
    for (int j = 0; j < 5; j++) begin
      push(t + j, K_TICK, 0, j == 3, "t5_tc_tick");
      push(t + j, K_LED, 0, j >= 3, "t5_tc_led");
    end
    do_write(0, MODE_BLINK, 2, 8'h00, 1'b0);
    wait_edges(4);

    // Back-to-back writes to ch1: OFF then ON, last one wins
    wb = edges + 1;
    push(wb, K_ACK, 0, 1'b1, "b2b_ack0");
    push(wb + 1, K_ACK, 0, 1'b1, "b2b_ack1");
    push(wb + 2, K_ACK, 0, 1'b0, "b2b_ack_end");
    push(wb, K_LED, 1, 1'b0, "b2b_off_led");
    for (int j = 1; j < 7; j++) begin
      push(wb + j, K_LED, 1, 1'b1, "b2b_on_led");
      push(wb + j, K_TICK, 1, j == 5, "b2b_on_tick");
    end
    CFG_WE = 1'b1; CFG_CH = 2'd1; CFG_MODE = MODE_OFF; CFG_DIV = 25'd0;
    CFG_PAT = 8'h00; CFG_INV = 1'b0;
    wait_edges(1);
    CFG_MODE = MODE_ON; CFG_DIV = 25'd3;
    wait_edges(1);
    CFG_WE = 1'b0;
    wait_edges(6);

    // 6: asynchronous reset pulse between edges
    n = edges;
    for (int c = 0; c < 3; c++) begin
      push(n, K_LED, c, 1'b0, "t6_rst_led");
      push(n, K_TICK, c, 1'b0, "t6_rst_tick");
    end
    RST_N = 1'b0;
    #6;
    RST_N = 1'b1;
    e0b = edges + 1;
    for (int i = 0; i < 15; i++) begin
      for (int c = 0; c < 3; c++) push_default(e0b + i, i, c, "t6_after_rst");
    end
    wait_edges(16);

    foreach (sb[k]) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s never checked (due edge %0d, now %0d)", sb[k].name, sb[k].at, edges);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
